ahb_to_sram_ctrl: RTL and testbench

//  AHB-Lite slave that drives the single-port byte-enabled SoC SRAM wrapper (8192x32).

---
 rtl/ahb_to_sram_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ahb_to_sram_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_to_sram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_to_sram_ctrl
//
// AHB-Lite slave in front of a single-port, byte-enabled 32-bit SRAM macro.
// Reads are zero-wait: the SRAM read strobe is issued in the AHB address
// phase and Q is returned in the data phase. Writes are issued in the AHB
// data phase, once HWDATA is valid.
//
// A write data phase followed by a read address phase would need the single
// SRAM port twice in one cycle. That write->read turnaround costs one wait
// state. Illegal sizes or misaligned transfers get a two-cycle ERROR response
// and never touch the SRAM.
//
// Parameters
//   AW         byte-address width; SRAM word address = HADDR[AW-1:2]
//
// Ports
//   HCLK       clock
//   HRESETn    asynchronous active-low reset
//   HSEL       slave select
//   HADDR      byte address [AW-1:0]
//   HTRANS     transfer type (bit 1 set = NONSEQ/SEQ)
//   HWRITE     1 = write
//   HSIZE      0 = byte, 1 = half, 2 = word, >2 illegal
//   HWDATA     write data (data phase)
//   HREADY     bus ready, qualifies address-phase accept
//   HREADYOUT  slave ready
//   HRESP      0 = OKAY, 1 = ERROR
//   HRDATA     read data
//   sram_q     SRAM Q, valid the cycle after a read strobe
//   sram_cen   SRAM chip enable, active low
//   sram_gwen  SRAM global write enable, active low
//   sram_ben   SRAM per-byte write enables, active low
//   sram_a     SRAM word address [AW-3:0]
//   sram_d     SRAM write data (always HWDATA)
// ---------------------------------------------------------------------------
module ahb_to_sram_ctrl #(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   sram_q,
    output logic          sram_cen,
    output logic          sram_gwen,
    output logic [3:0]    sram_ben,
    output logic [AW-3:0] sram_a,
    output logic [31:0]   sram_d
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_WR_STALL,
        S_RD_RETRY,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-3:0] wr_addr_p1;
    logic [AW-3:0] wr_addr_nxt;
    logic [3:0]    wr_mask_p1;
    logic [3:0]    wr_mask_nxt;

    logic accept;
    logic illegal;
    logic rd_cand;
    logic take;

    function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = lsb[0];
            3'd2:    bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Active-high byte lanes touched by a legal transfer.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] m;
        m = 4'hF;
        case (size)
            3'd0:    m = 4'b0001 << lsb;
            3'd1:    m = 4'b0011 << {lsb[1], 1'b0};
            default: m = 4'hF;
        endcase
        return m;
    endfunction

    // Reset also gates the accept so that outputs go inactive the moment
    // HRESETn falls, even if the bus keeps presenting a transfer.
    assign accept  = HRESETn & HSEL & HREADY & HTRANS[1];
    assign illegal = size_illegal(HSIZE, HADDR[1:0]);
    assign rd_cand = HSEL & HTRANS[1] & ~HWRITE;
    assign sram_d  = HWDATA;

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr_p1;
        wr_mask_nxt = wr_mask_p1;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = '0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_ben    = 4'hF;
        sram_a      = '0;
        take        = 1'b0;

        case (state)
            S_IDLE: begin
                take = 1'b1;
            end
            S_RD: begin
                HRDATA = sram_q;
                take   = 1'b1;
            end
            S_WR: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_ben  = ~wr_mask_p1;
                sram_a    = wr_addr_p1;
                // A read waiting in its address phase cannot share the port
                // with this write: hold it off for exactly one cycle.
                if (rd_cand) begin
                    HREADYOUT = 1'b0;
                    state_nxt = S_WR_STALL;
                end else begin
                    take = 1'b1;
                end
            end
            S_WR_STALL: begin
                take = 1'b1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP = 1'b1;
                take  = 1'b1;
            end
            default: begin
                // Reserved encoding (RD_RETRY and unused codes): idle outputs.
                state_nxt = S_IDLE;
            end
        endcase

        // Address-phase decode, shared by every state that can accept.
        if (take) begin
            state_nxt = S_IDLE;
            if (accept) begin
                if (illegal) begin
                    state_nxt = S_ERR1;
                end else if (!HWRITE) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b1;
                    sram_a    = HADDR[AW-1:2];
                    state_nxt = S_RD;
                end else begin
                    wr_addr_nxt = HADDR[AW-1:2];
                    wr_mask_nxt = lane_mask(HSIZE, HADDR[1:0]);
                    state_nxt   = S_WR;
                end
            end
        end
    end

    // ---- address phase -> data phase ----
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            wr_addr_p1 <= '0;
            wr_mask_p1 <= '0;
        end else begin
            state      <= state_nxt;
            wr_addr_p1 <= wr_addr_nxt;
            wr_mask_p1 <= wr_mask_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_to_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_to_sram_ctrl
//
// Directed bench for ahb_to_sram_ctrl with a behavioural SRAM model.
// The driver issues pipelined AHB transfers and pushes hand-computed
// expectations (data-phase responses and SRAM strobes) into queues; an
// independent monitor pops and compares whenever the DUT completes a data
// phase or strobes the SRAM.
// ---------------------------------------------------------------------------
module tb_ahb_to_sram_ctrl;

    localparam int AW = 15;

    logic          HCLK;
    logic          HRESETn;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   sram_q;
    logic          sram_cen;
    logic          sram_gwen;
    logic [3:0]    sram_ben;
    logic [AW-3:0] sram_a;
    logic [31:0]   sram_d;

    // Single slave on the bus: HREADY is this slave's own HREADYOUT.
    assign HREADY = HREADYOUT;

    ahb_to_sram_ctrl #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .sram_q    (sram_q),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_ben  (sram_ben),
        .sram_a    (sram_a),
        .sram_d    (sram_d)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Behavioural SRAM: synchronous, Q registered on read strobes.
    logic [31:0] mem [0:(1<<(AW-2))-1];
    always @(posedge HCLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_ben[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    typedef struct {
        int          waits;
        logic        resp;
        logic        is_rd;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic          gwen;
        logic [3:0]    ben;
        logic [AW-3:0] a;
        logic [31:0]   d;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];

    int   n_cmp;
    int   n_fail;
    logic push_en;

    localparam logic [1:0] IDLE_T = 2'b00;
    localparam logic [1:0] BUSY_T = 2'b01;
    localparam logic [1:0] NSEQ   = 2'b10;
    localparam logic [2:0] SZ_B   = 3'd0;
    localparam logic [2:0] SZ_H   = 3'd1;
    localparam logic [2:0] SZ_W   = 3'd2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic exp_wr(input logic [3:0] ben, input logic [AW-3:0] a, input logic [31:0] d);
        acc_t e;
        e.gwen = 1'b0; e.ben = ben; e.a = a; e.d = d;
        acc_q.push_back(e);
    endtask

    task automatic exp_rd(input logic [AW-3:0] a);
        acc_t e;
        e.gwen = 1'b1; e.ben = 4'hF; e.a = a; e.d = '0;
        acc_q.push_back(e);
    endtask

    // Drive one address phase, wait for it to be accepted, then drive its
    // write data (if any) for the data phase that follows.
    task automatic bus(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input int waits, input logic resp,
                       input logic [31:0] rdata);
        rsp_t r;
        logic ok;
        int   n;
        HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = addr;
        if (push_en && sel && tr[1]) begin
            r.waits = waits; r.resp = resp; r.is_rd = ~wr; r.rdata = rdata;
            rsp_q.push_back(r);
        end
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge HCLK);
            ok = HREADYOUT;
            @(posedge HCLK);
            n++;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bus_accept_timeout: HREADYOUT low for %0d cycles, required accept", n);
        end
        #1;
        if (wr) HWDATA = wd;
    endtask

    task automatic idle();
        bus(1'b0, IDLE_T, 1'b0, SZ_W, '0, '0, 0, 1'b0, '0);
    endtask

    // Monitor: checks SRAM strobes and data-phase completions.
    logic dp_pend;
    logic dp_first;
    logic dp_first_resp;
    int   dp_waits;

    initial begin
        dp_pend = 1'b0; dp_first = 1'b0; dp_first_resp = 1'b0; dp_waits = 0;
    end

    always @(negedge HCLK) begin
        acc_t e;
        rsp_t r;
        if (!HRESETn) begin
            dp_pend  = 1'b0;
            dp_first = 1'b0;
            dp_waits = 0;
        end else begin
            if (!sram_cen) begin
                if (acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sram_unexpected: access gwen=%0b a=0x%04h, required none",
                             sram_gwen, sram_a);
                end else begin
                    e = acc_q.pop_front();
                    chk("sram_gwen", {31'd0, sram_gwen}, {31'd0, e.gwen});
                    chk("sram_a", {{(34-AW){1'b0}}, sram_a}, {{(34-AW){1'b0}}, e.a});
                    if (!e.gwen) begin
                        chk("sram_ben", {28'd0, sram_ben}, {28'd0, e.ben});
                        chk("sram_d", sram_d, e.d);
                    end
                end
            end
            if (dp_pend) begin
                if (dp_first) begin
                    dp_first_resp = HRESP;
                    dp_first      = 1'b0;
                end
                if (HREADYOUT) begin
                    dp_pend = 1'b0;
                    if (rsp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: data phase completed, required none");
                    end else begin
                        r = rsp_q.pop_front();
                        chk("wait_states", dp_waits, r.waits);
                        chk("hresp_first", {31'd0, dp_first_resp}, {31'd0, r.resp});
                        chk("hresp_last", {31'd0, HRESP}, {31'd0, r.resp});
                        if (r.is_rd && !r.resp) chk("hrdata", HRDATA, r.rdata);
                    end
                end else begin
                    dp_waits++;
                end
            end
            if (HREADYOUT && HSEL && HTRANS[1]) begin
                dp_pend  = 1'b1;
                dp_first = 1'b1;
                dp_waits = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_fail = 0; push_en = 1'b1;
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = IDLE_T; HWRITE = 1'b0;
        HSIZE = SZ_W; HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_cen", {31'd0, sram_cen}, 32'd1);
        chk("rst_gwen", {31'd0, sram_gwen}, 32'd1);
        chk("rst_ben", {28'd0, sram_ben}, 32'hF);
        chk("rst_a", {19'd0, sram_a}, 32'd0);
        #2 HRESETn = 1'b1;

        // Word write then read of the same word: one turnaround wait.
        exp_wr(4'b0000, 13'd4, 32'hDEADBEEF);
        bus(1, NSEQ, 1, SZ_W, 15'h0010, 32'hDEADBEEF, 1, 0, '0);
        exp_rd(13'd4);
        bus(1, NSEQ, 0, SZ_W, 15'h0010, '0, 0, 0, 32'hDEADBEEF);
        idle();

        // Byte write to lane 3, read back merged word.
        exp_wr(4'b0111, 13'd4, 32'hAA000000);
        bus(1, NSEQ, 1, SZ_B, 15'h0013, 32'hAA000000, 1, 0, '0);
        exp_rd(13'd4);
        bus(1, NSEQ, 0, SZ_W, 15'h0010, '0, 0, 0, 32'hAAADBEEF);
        idle();

        // Back-to-back writes followed by IDLE: no wait states.
        exp_wr(4'b0000, 13'd8, 32'h20202020);
        bus(1, NSEQ, 1, SZ_W, 15'h0020, 32'h20202020, 0, 0, '0);
        exp_wr(4'b0000, 13'd9, 32'h24242424);
        bus(1, NSEQ, 1, SZ_W, 15'h0024, 32'h24242424, 0, 0, '0);
        idle();

        exp_wr(4'b0000, 13'd0, 32'h11111111);
        bus(1, NSEQ, 1, SZ_W, 15'h0000, 32'h11111111, 0, 0, '0);
        exp_wr(4'b0000, 13'd1, 32'h22222222);
        bus(1, NSEQ, 1, SZ_W, 15'h0004, 32'h22222222, 0, 0, '0);
        exp_wr(4'b0000, 13'd2, 32'h33333333);
        bus(1, NSEQ, 1, SZ_W, 15'h0008, 32'h33333333, 0, 0, '0);
        idle();

        // Back-to-back reads: zero wait.
        exp_rd(13'd0);
        bus(1, NSEQ, 0, SZ_W, 15'h0000, '0, 0, 0, 32'h11111111);
        exp_rd(13'd1);
        bus(1, NSEQ, 0, SZ_W, 15'h0004, '0, 0, 0, 32'h22222222);
        exp_rd(13'd2);
        bus(1, NSEQ, 0, SZ_W, 15'h0008, '0, 0, 0, 32'h33333333);
        idle();

        // Upper halfword write, then read.
        exp_wr(4'b0011, 13'd9, 32'hBEEF0000);
        bus(1, NSEQ, 1, SZ_H, 15'h0026, 32'hBEEF0000, 1, 0, '0);
        exp_rd(13'd9);
        bus(1, NSEQ, 0, SZ_W, 15'h0024, '0, 0, 0, 32'hBEEF2424);
        idle();

        // Selected but IDLE/BUSY: no SRAM access, no data phase.
        bus(1, BUSY_T, 0, SZ_W, 15'h0010, '0, 0, 0, '0);
        bus(1, IDLE_T, 1, SZ_W, 15'h0010, '0, 0, 0, '0);

        // Misaligned word read, then a legal read accepted in ERR2.
        bus(1, NSEQ, 0, SZ_W, 15'h0002, '0, 1, 1, '0);
        exp_rd(13'd0);
        bus(1, NSEQ, 0, SZ_W, 15'h0000, '0, 0, 0, 32'h11111111);
        idle();

        // Odd halfword write and oversize read: both ERROR, memory untouched.
        bus(1, NSEQ, 1, SZ_H, 15'h0005, 32'hFFFFFFFF, 1, 1, '0);
        bus(1, NSEQ, 0, 3'd3, 15'h0008, '0, 1, 1, '0);
        exp_rd(13'd1);
        bus(1, NSEQ, 0, SZ_W, 15'h0004, '0, 0, 0, 32'h22222222);
        idle();

        // Top of the address space.
        exp_wr(4'b0000, 13'h1FFF, 32'hCAFEF00D);
        bus(1, NSEQ, 1, SZ_W, 15'h7FFC, 32'hCAFEF00D, 1, 0, '0);
        exp_rd(13'h1FFF);
        bus(1, NSEQ, 0, SZ_W, 15'h7FFC, '0, 0, 0, 32'hCAFEF00D);
        idle();

        // Reset asserted in the middle of a write data phase.
        push_en = 1'b0;
        bus(1, NSEQ, 1, SZ_W, 15'h0010, 32'h12345678, 0, 0, '0);
        push_en = 1'b1;
        HSEL = 1'b0; HTRANS = IDLE_T;
        #1;
        chk("wr_phase_gwen", {31'd0, sram_gwen}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("arst_cen", {31'd0, sram_cen}, 32'd1);
        chk("arst_gwen", {31'd0, sram_gwen}, 32'd1);
        chk("arst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        exp_rd(13'd4);
        bus(1, NSEQ, 0, SZ_W, 15'h0010, '0, 0, 0, 32'hAAADBEEF);
        idle();
        idle();

        repeat (2) @(negedge HCLK);
        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        chk("no_dphase_pending", {31'd0, dp_pend}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
